// File: rtl/axi_lite_settings_bridge.sv
// axi_lite_settings_bridge
// Bridges a single AXI-Lite slave port onto a simple settings bus:
// writes become a one-cycle set_stb, reads a one-cycle get_stb with
// get_data sampled combinationally in that same cycle.
// Only one transaction is in flight at a time; writes win over reads.
//
// Optional feature macro: SETTINGS_WSTRB_CHECK_EN
//   defined   -> partial-strobe writes are dropped and answered with SLVERR
//   undefined -> wstrb is ignored, every write pulses set_stb, bresp = OKAY
//
// Handshakes: a transfer on any AXI channel happens on the rising edge
// where both valid and ready are high; valid never depends on ready, and
// bvalid/rvalid with their payloads stay stable until the matching ready.
module axi_lite_settings_bridge #(
   parameter int C_DATAWIDTH = 32,
   parameter int C_ADDRWIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // write address
   input  logic [C_ADDRWIDTH-1:0]   s_axi_awaddr,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   // write data
   input  logic [C_DATAWIDTH-1:0]   s_axi_wdata,
   input  logic [C_DATAWIDTH/8-1:0] s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   // write response
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   // read address
   input  logic [C_ADDRWIDTH-1:0]   s_axi_araddr,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   // read data
   output logic [C_DATAWIDTH-1:0]   s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   // settings write bus
   output logic [C_DATAWIDTH-1:0]   set_data,
   output logic [C_ADDRWIDTH-1:0]   set_addr,
   output logic                     set_stb,
   // settings read bus
   output logic [C_ADDRWIDTH-1:0]   get_addr,
   output logic                     get_stb,
   input  logic [C_DATAWIDTH-1:0]   get_data,
   // FSM state for observation
   output logic [2:0]               dbg_state
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      BRESP = 3'd2,
      GET   = 3'd3,
      RRESP = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // AW and W are captured independently while idle
   logic                   aw_done;
   logic                   w_done;
   logic [C_ADDRWIDTH-1:0] aw_addr_q;
   logic [C_DATAWIDTH-1:0] w_data_q;
   logic                   strb_ok_q;

   logic                   aw_hs;
   logic                   w_hs;
   logic                   ar_hs;
   logic                   wr_go;
   logic [C_ADDRWIDTH-1:0] wr_addr;
   logic [C_DATAWIDTH-1:0] wr_data;
   logic                   wr_strb_ok;

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid  & s_axi_wready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;

   // a write starts on the edge where both halves are held, counting
   // halves that are being handed over on this very edge
   assign wr_go   = (state == IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
   assign wr_addr = aw_done ? aw_addr_q : s_axi_awaddr;
   assign wr_data = w_done  ? w_data_q  : s_axi_wdata;

`ifdef SETTINGS_WSTRB_CHECK_EN
   logic [C_DATAWIDTH/8-1:0] w_strb_q;
   logic [C_DATAWIDTH/8-1:0] wr_strb;

   assign wr_strb    = w_done ? w_strb_q : s_axi_wstrb;
   assign wr_strb_ok = &wr_strb;

   // keep the captured strobe alongside the captured data
   always_ff @(posedge clk) begin
      if (!rst_n)
         w_strb_q <= '0;
      else if (w_hs)
         w_strb_q <= s_axi_wstrb;
   end
`else
   logic unused_wstrb;

   assign unused_wstrb = ^s_axi_wstrb;
   assign wr_strb_ok   = 1'b1;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wr_go)
               state_nxt = SET;
            else if (ar_hs)
               state_nxt = GET;
         end
         SET:   state_nxt = BRESP;
         BRESP: if (s_axi_bready) state_nxt = IDLE;
         GET:   state_nxt = RRESP;
         RRESP: if (s_axi_rready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake and strobe outputs; forced low while reset is held so an
   // abandoned transaction cannot leak a strobe or response
   always_comb begin
      s_axi_awready = rst_n && (state == IDLE) && !aw_done;
      s_axi_wready  = rst_n && (state == IDLE) && !w_done;
      s_axi_arready = rst_n && (state == IDLE) && !aw_done && !w_done &&
                      !s_axi_awvalid && !s_axi_wvalid;
      s_axi_bvalid  = rst_n && (state == BRESP);
      s_axi_rvalid  = rst_n && (state == RRESP);
      set_stb       = rst_n && (state == SET) && strb_ok_q;
      get_stb       = rst_n && (state == GET);
      s_axi_rresp   = RESP_OKAY;
      dbg_state     = state;
   end

   // capture flags and held AW/W payloads, released when the response completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
      end else if ((state == BRESP) && s_axi_bready) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_done   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_done   <= 1'b1;
            w_data_q <= s_axi_wdata;
         end
      end
   end

   // settings-bus and response registers; each only changes when a new
   // transaction loads it, so outputs hold between strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         set_addr    <= '0;
         set_data    <= '0;
         strb_ok_q   <= 1'b0;
         s_axi_bresp <= RESP_OKAY;
         get_addr    <= '0;
         s_axi_rdata <= '0;
      end else begin
         if (wr_go) begin
            set_addr    <= wr_addr;
            set_data    <= wr_data;
            strb_ok_q   <= wr_strb_ok;
            s_axi_bresp <= wr_strb_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (ar_hs)
            get_addr <= s_axi_araddr;
         if (state == GET)
            s_axi_rdata <= get_data;
      end
   end

endmodule

// File: tb/tb_axi_lite_settings_bridge.sv
// Testbench for axi_lite_settings_bridge: directed scenarios followed by
// randomized writes/reads, checked against a transaction-level model
// (expected set/get queues, rdata = get_addr ^ RD_KEY).
module tb_axi_lite_settings_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] RD_KEY = 32'hACE0BA53;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [AW-1:0]   s_axi_awaddr;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic [AW-1:0]   s_axi_araddr;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  logic [DW-1:0]   set_data;
  logic [AW-1:0]   set_addr;
  logic            set_stb;
  logic [AW-1:0]   get_addr;
  logic            get_stb;
  logic [DW-1:0]   get_data;
  logic [2:0]      dbg_state;

  // settings read slave: answers only while strobed
  assign get_data = get_stb ? (get_addr ^ RD_KEY) : 32'h0;

  axi_lite_settings_bridge #(.C_DATAWIDTH(DW), .C_ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_addr(get_addr), .get_stb(get_stb), .get_data(get_data),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [63:0] exp_set_q[$];
  logic [31:0] exp_get_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit ar_pending = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // strobe monitor: every strobe must match the next expected transaction
  always @(negedge clk) begin
    if (set_stb && get_stb)
      check("stb_overlap", 1, 0);
    if (set_stb) begin
      if (exp_set_q.size() == 0)
        check("set_spurious", 1, 0);
      else
        check("set_xfer", {set_addr, set_data}, exp_set_q.pop_front());
    end
    if (get_stb) begin
      if (exp_get_q.size() == 0)
        check("get_spurious", 1, 0);
      else
        check("get_addr", get_addr, exp_get_q.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                          s_axi_rvalid, set_stb, get_stb}, 0);
    check({tag, "_set"}, {set_addr, set_data}, 0);
    check({tag, "_get_addr"}, get_addr, 0);
    check({tag, "_rdata"}, s_axi_rdata, 0);
    check({tag, "_resp"}, {s_axi_bresp, s_axi_rresp}, 0);
  endtask

  // driver: write with independent AW/W start delays and a bready delay
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_ok = 0;
    bit w_ok = 0;
    bit aw_now, w_now, ok;
    int cyc = 0;
    logic [1:0] exp_b;
`ifdef SETTINGS_WSTRB_CHECK_EN
    ok = (s == 4'hF);
`else
    ok = 1'b1;
`endif
    exp_b = ok ? 2'b00 : 2'b10;
    if (ok) exp_set_q.push_back({a, d});
    s_axi_awaddr = a;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    while (!(aw_ok && w_ok)) begin
      s_axi_awvalid = !aw_ok && (cyc >= aw_dly);
      s_axi_wvalid  = !w_ok && (cyc >= w_dly);
      @(negedge clk);
      check("awready", s_axi_awready, !aw_ok);
      check("wready", s_axi_wready, !w_ok);
      check("early_set", set_stb, 0);
      check("early_bvalid", s_axi_bvalid, 0);
      if (ar_pending) check("ar_blocked", s_axi_arready, 0);
      aw_now = s_axi_awvalid && s_axi_awready;
      w_now  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_now) aw_ok = 1;
      if (w_now) w_ok = 1;
      cyc++;
      if (cyc > 40) begin
        check("wr_hs_timeout", 0, 1);
        break;
      end
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    @(negedge clk);
    check("set_stb_lat", set_stb, ok);
    check("bvalid_early", s_axi_bvalid, 0);
    if (ar_pending) check("ar_blocked_set", s_axi_arready, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= b_dly; i++) begin
      if (i == b_dly) s_axi_bready = 1;
      @(negedge clk);
      check("bvalid", s_axi_bvalid, 1);
      check("bresp", s_axi_bresp, exp_b);
      check("set_once", set_stb, 0);
      check("rdy_busy_w", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
      @(posedge clk); #1;
    end
    s_axi_bready = 0;
  endtask

  // driver: read with an rready delay
  task automatic axi_read(input logic [31:0] a, input int r_dly);
    bit hs = 0;
    int cyc = 0;
    logic [31:0] exp_d;
    exp_d = a ^ RD_KEY;
    exp_get_q.push_back(a);
    s_axi_araddr  = a;
    s_axi_arvalid = 1;
    while (!hs) begin
      @(negedge clk);
      if (cyc == 0) check("arready_idle", s_axi_arready, 1);
      check("early_get", get_stb, 0);
      hs = s_axi_arready;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 40) begin
        check("rd_hs_timeout", 0, 1);
        break;
      end
    end
    s_axi_arvalid = 0;
    @(negedge clk);
    check("get_stb_lat", get_stb, 1);
    check("rvalid_early", s_axi_rvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= r_dly; i++) begin
      if (i == r_dly) s_axi_rready = 1;
      @(negedge clk);
      check("rvalid", s_axi_rvalid, 1);
      check("rdata", s_axi_rdata, exp_d);
      check("rresp", s_axi_rresp, 0);
      check("get_once", get_stb, 0);
      check("rdy_busy_r", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
      @(posedge clk); #1;
    end
    s_axi_rready = 0;
  endtask

  initial begin
    rst_n = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0;
    s_axi_araddr = 0; s_axi_arvalid = 0;
    s_axi_rready = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge clk); #1;

    // simultaneous AW/W
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    // W three cycles ahead of AW
    axi_write(32'h10, 32'h5, 4'hF, 3, 0, 1);
    // AW ahead of W, unaligned address passes through unmodified
    axi_write(32'h23, 32'h1234_5678, 4'hF, 0, 2, 2);
    // read with rready held low for 5 cycles
    axi_read(32'h0, 5);

    // write and read arrive together: write first, then read
    ar_pending = 1;
    s_axi_araddr = 32'h8;
    s_axi_arvalid = 1;
    axi_write(32'h30, 32'h0000_BEEF, 4'hF, 0, 0, 0);
    ar_pending = 0;
    axi_read(32'h8, 1);

    // partial strobe
    axi_write(32'h40, 32'h0000_CAFE, 4'b0011, 0, 0, 0);

    // reset right after an AW/W handshake abandons the write
    s_axi_awaddr = 32'h50; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge clk);
    check("pre_rst_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    rst_n = 0;
    @(negedge clk);
    check("rst_no_set", set_stb, 0);
    check("rst_no_bvalid", s_axi_bvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {set_stb, s_axi_bvalid, s_axi_rvalid}, 0);
      check("post_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      @(posedge clk); #1;
    end
    axi_write(32'h60, 32'hA5A5_0F0F, 4'hF, 1, 1, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      a = $urandom;
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    check("set_left", exp_set_q.size(), 0);
    check("get_left", exp_get_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_settings_bridge.md
AXI_LITE_SETTINGS_BRIDGE -- requirements
Module: axi_lite_settings_bridge

Interface
REQ-001 SHALL have parameter C_DATAWIDTH, default 32: AXI data, set_data and get_data width.
REQ-002 SHALL have parameter C_ADDRWIDTH, default 32: AXI address, set_addr and get_addr width.
REQ-003 SHALL use one clock and a synchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, sampled on clk only.
REQ-004 SHALL have AXI-Lite write-address ports: s_axi_awaddr in C_ADDRWIDTH; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-005 SHALL have AXI-Lite write-data ports: s_axi_wdata in C_DATAWIDTH; s_axi_wstrb in C_DATAWIDTH/8; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-006 SHALL have AXI-Lite write-response ports: s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-007 SHALL have AXI-Lite read-address ports: s_axi_araddr in C_ADDRWIDTH; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-008 SHALL have AXI-Lite read-data ports: s_axi_rdata out C_DATAWIDTH; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-009 SHALL have settings-write outputs: set_data out C_DATAWIDTH; set_addr out C_ADDRWIDTH; set_stb out 1, one-cycle write strobe.
REQ-010 SHALL have settings-read ports: get_addr out C_ADDRWIDTH; get_stb out 1; get_data in C_DATAWIDTH, combinational response valid in the same cycle as get_stb.

Function
REQ-011 SHALL implement FSM states IDLE, SET, BRESP, GET, RRESP.
REQ-012 In IDLE, s_axi_awready SHALL be high while AW is not yet captured, and s_axi_wready SHALL be high while W is not yet captured; AW and W SHALL be captured independently, in either order or in the same cycle.
REQ-013 IDLE SHALL go to SET on the edge where both AW and W are held.
REQ-014 SET SHALL last exactly one cycle, with set_stb=1, set_addr=captured awaddr (unmodified, low bits included) and set_data=captured wdata.
REQ-015 SET SHALL go to BRESP; BRESP SHALL hold s_axi_bvalid=1 and a stable bresp until s_axi_bready, then return to IDLE and clear both capture flags.
REQ-016 s_axi_arready SHALL be high only in IDLE with no AW/W captured and s_axi_awvalid=0 and s_axi_wvalid=0 (writes have priority on simultaneous arrival).
REQ-017 An AR handshake SHALL capture araddr and go to GET.
REQ-018 GET SHALL last one cycle with get_stb=1 and get_addr=captured araddr, register get_data into s_axi_rdata, then go to RRESP.
REQ-019 RRESP SHALL hold s_axi_rvalid=1, rresp=2'b00 and a stable rdata until s_axi_rready, then return to IDLE.
REQ-020 Latency from AW+W handshake to set_stb SHALL be 1 cycle and to bvalid 2 cycles; latency from AR handshake to get_stb SHALL be 1 cycle and to rvalid 2 cycles.
REQ-021 The block SHALL have at most one outstanding transaction; no ready signal SHALL be asserted outside IDLE.
REQ-022 set_stb and get_stb SHALL never be high together, and each SHALL fire exactly once per accepted transaction.
REQ-023 When a strobe is low, its address and data outputs SHALL hold their last values.

Reset
REQ-024 While rst_n=0, the FSM SHALL be in IDLE with capture flags cleared, and all ready, valid and strobe outputs, set_addr, set_data, get_addr, s_axi_rdata, bresp and rresp SHALL be 0.
REQ-025 A reset asserted mid-transaction SHALL abandon it: no set_stb or get_stb SHALL follow, and no response SHALL be issued.
REQ-026 Out of reset, the first accepted transaction SHALL behave per REQ-012..REQ-019.

Configuration
REQ-027 When macro SETTINGS_WSTRB_CHECK_EN is defined, a write whose captured wstrb is not all-ones SHALL suppress set_stb in SET (state still one cycle) and return bresp=2'b10 (SLVERR); a full-strobe write SHALL return 2'b00.
REQ-028 When SETTINGS_WSTRB_CHECK_EN is undefined, wstrb SHALL be ignored, every write SHALL pulse set_stb and bresp SHALL always be 2'b00.

Verification
REQ-029 Simultaneous AW/W, awaddr=0x4, wdata=0xDEADBEEF -> set_stb one cycle later with set_addr=0x4, set_data=0xDEADBEEF; bvalid the next cycle; bresp=0.
REQ-030 W sent 3 cycles before AW (addr 0x10, data 0x5) -> single set_stb only after AW arrives; wready low after W capture.
REQ-031 Read of araddr=0x0 with get_data tied to 0xACE0BA53 when get_stb -> rdata=0xACE0BA53, rvalid 2 cycles after AR; rready held low 5 cycles -> rvalid and rdata stable.
REQ-032 awvalid, wvalid and arvalid asserted in the same cycle -> write completes first, arready=0 until back in IDLE, then read served.
REQ-033 rst_n=0 in the cycle after an AW/W handshake -> no set_stb and no bvalid; all outputs 0.
REQ-034 With SETTINGS_WSTRB_CHECK_EN, wstrb=4'b0011 -> no set_stb and bresp=2'b10; without the macro -> set_stb and bresp=0.
